// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
// Holds the channel FSM encoding, the default clock rate and the ms divider helper.
package button_conditioner_pkg;

    localparam int DEF_CLK_HZ = 27000000;

    typedef enum logic [1:0] {
        BTN_IDLE = 2'd0,
        BTN_DOWN = 2'd1,
        BTN_HELD = 2'd2
    } btn_state_t;

    // Divider for the 1 ms tick, never below 1 so slow test clocks still tick.
    function automatic int ms_div(input int clk_hz);
        int d;
        d = clk_hz / 1000;
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce and press classifier.
// Ports: CLK, RST (async high), TICK (1 ms strobe), BTN_N (raw, active-low);
//        PRESSED level and 1-cycle PRESS_P / RELEASE_P / LONG_P pulses.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic TICK,
    input  logic BTN_N,
    output logic PRESSED,
    output logic PRESS_P,
    output logic RELEASE_P,
    output logic LONG_P
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);

    logic          ff1;
    logic          ff2;
    logic          s;
    logic          level;
    logic          ev_press;
    logic          ev_release;
    logic [DW-1:0] cnt;
    logic [HW-1:0] hold;
    btn_state_t    state;

    assign s = ~ff2;

    // Preset to released so leaving reset with idle buttons is silent.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
        end else begin
            ff1 <= BTN_N;
            ff2 <= ff1;
        end
    end

    // level is the accepted state; events are registered so the FSM
    // stage adds the one output register of latency.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level      <= 1'b0;
            cnt        <= '0;
            ev_press   <= 1'b0;
            ev_release <= 1'b0;
        end else begin
            ev_press   <= 1'b0;
            ev_release <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (TICK) begin
                if (cnt == DB_LAST) begin
                    level      <= s;
                    cnt        <= '0;
                    ev_press   <= s;
                    ev_release <= ~s;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Release is tested first so it beats a coincident long-press expiry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= BTN_IDLE;
            hold      <= '0;
            PRESSED   <= 1'b0;
            PRESS_P   <= 1'b0;
            RELEASE_P <= 1'b0;
            LONG_P    <= 1'b0;
        end else begin
            PRESS_P   <= 1'b0;
            RELEASE_P <= 1'b0;
            LONG_P    <= 1'b0;
            unique case (state)
                BTN_IDLE: begin
                    if (ev_press) begin
                        state   <= BTN_DOWN;
                        hold    <= '0;
                        PRESSED <= 1'b1;
                        PRESS_P <= 1'b1;
                    end
                end
                BTN_DOWN: begin
                    if (ev_release) begin
                        state     <= BTN_IDLE;
                        PRESSED   <= 1'b0;
                        RELEASE_P <= 1'b1;
                    end else if (TICK) begin
                        if (hold == HOLD_LAST) begin
                            state  <= BTN_HELD;
                            LONG_P <= 1'b1;
                        end else begin
                            hold <= hold + 1'b1;
                        end
                    end
                end
                BTN_HELD: begin
                    if (ev_release) begin
                        state     <= BTN_IDLE;
                        PRESSED   <= 1'b0;
                        RELEASE_P <= 1'b1;
                    end
                end
                default: begin
                    state   <= BTN_IDLE;
                    PRESSED <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTNS raw active-low push-buttons and exports the shared 1 ms tick.
// Ports: CLK, RST (async high), BTNS_N; PRESSED, PRESS_P, RELEASE_P, LONG_P, TICK_1MS.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int NUM_BTNS    = 2,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NUM_BTNS-1:0] BTNS_N,
    output logic [NUM_BTNS-1:0] PRESSED,
    output logic [NUM_BTNS-1:0] PRESS_P,
    output logic [NUM_BTNS-1:0] RELEASE_P,
    output logic [NUM_BTNS-1:0] LONG_P,
    output logic                TICK_1MS
);

    localparam int DIV = ms_div(CLK_HZ);
    localparam logic [31:0] TMAX = 32'(DIV - 1);

    logic [31:0] tcnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt     <= '0;
            TICK_1MS <= 1'b0;
        end else begin
            TICK_1MS <= (tcnt == TMAX);
            tcnt     <= (tcnt == TMAX) ? '0 : tcnt + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS)
        ) u_ch (
            .CLK      (CLK),
            .RST      (RST),
            .TICK     (TICK_1MS),
            .BTN_N    (BTNS_N[i]),
            .PRESSED  (PRESSED[i]),
            .PRESS_P  (PRESS_P[i]),
            .RELEASE_P(RELEASE_P[i]),
            .LONG_P   (LONG_P[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner against a behavioural model.
// Runs with a 1-cycle tick divider so every cycle is a millisecond.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int DB = 20;
    localparam int LG = 100;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [NB-1:0] BTNS_N = '1;
    logic [NB-1:0] PRESSED;
    logic [NB-1:0] PRESS_P;
    logic [NB-1:0] RELEASE_P;
    logic [NB-1:0] LONG_P;
    logic          TICK_1MS;

    button_conditioner #(
        .CLK_HZ     (1000),
        .NUM_BTNS   (NB),
        .DEBOUNCE_MS(DB),
        .LONG_MS    (LG)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTNS_N   (BTNS_N),
        .PRESSED  (PRESSED),
        .PRESS_P  (PRESS_P),
        .RELEASE_P(RELEASE_P),
        .LONG_P   (LONG_P),
        .TICK_1MS (TICK_1MS)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model: raw input history since reset release, per-channel accepted
    // level and run length, pending events, and press classification.
    int            e;
    bit [NB-1:0]   raw_q[$];
    bit            lvl[NB];
    int            run[NB];
    bit            evp[NB];
    bit            evr[NB];
    int            hold[NB];
    bit            fired[NB];
    bit [NB-1:0]   m_pr, m_pp, m_rp, m_lp;
    bit            m_tick;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        e = 0;
        raw_q.delete();
        for (int c = 0; c < NB; c++) begin
            lvl[c] = 0; run[c] = 0; evp[c] = 0; evr[c] = 0;
            hold[c] = 0; fired[c] = 0;
        end
        m_pr = '0; m_pp = '0; m_rp = '0; m_lp = '0; m_tick = 0;
    endtask

    // One clock edge of the model: the sampled input seen by the
    // debouncer is the pin value two edges back.
    task automatic model_edge();
        bit s;
        e++;
        m_tick = 1'b1;
        m_pp = '0; m_rp = '0; m_lp = '0;
        for (int c = 0; c < NB; c++) begin
            if (evr[c]) begin
                m_pr[c] = 0; m_rp[c] = 1;
            end else if (evp[c]) begin
                m_pr[c] = 1; m_pp[c] = 1; hold[c] = 0; fired[c] = 0;
            end else if (m_pr[c] && !fired[c]) begin
                hold[c]++;
                if (hold[c] == LG) begin
                    m_lp[c] = 1; fired[c] = 1;
                end
            end
            evp[c] = 0; evr[c] = 0;
            s = (e >= 3) ? ~raw_q[e-3][c] : 1'b0;
            if (s != lvl[c]) begin
                run[c]++;
                if (run[c] == DB) begin
                    lvl[c] = s; run[c] = 0;
                    if (s) evp[c] = 1; else evr[c] = 1;
                end
            end else begin
                run[c] = 0;
            end
        end
    endtask

    task automatic step();
        raw_q.push_back(BTNS_N);
        @(posedge CLK);
        #1;
        cyc++;
        model_edge();
        chk("outputs", {23'd0, PRESSED, PRESS_P, RELEASE_P, LONG_P, TICK_1MS},
            {23'd0, m_pr, m_pp, m_rp, m_lp, m_tick});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // kind: 0 press, 1 release, 2 long
    task automatic wait_pulse(input int ch, input int kind, input int maxc,
                              output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            case (kind)
                0: hit = PRESS_P[ch];
                1: hit = RELEASE_P[ch];
                default: hit = LONG_P[ch];
            endcase
            if (hit) begin
                at = cyc;
                break;
            end
        end
    endtask

    int t0, a, b;
    int rem[NB];

    initial begin
        model_reset();
        BTNS_N = '1;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_out", {PRESSED, PRESS_P, RELEASE_P, LONG_P, TICK_1MS}, 0);
        RST = 1'b0;

        // idle after reset: no pulses, tick running
        steps(200);
        chk("idle_tick", TICK_1MS, 1);

        // clean press, channel 1 idle
        t0 = cyc; BTNS_N[0] = 1'b0;
        wait_pulse(0, 0, 40, a);
        chk("press_lat", a - t0, 23);
        chk("press_lvl", PRESSED, 2'b01);
        BTNS_N[0] = 1'b1;
        steps(60);

        // bounce then steady low
        BTNS_N[0] = 1'b0; steps(15);
        BTNS_N[0] = 1'b1; steps(3);
        t0 = cyc; BTNS_N[0] = 1'b0;
        wait_pulse(0, 0, 40, a);
        chk("bounce_lat", a - t0, 23);
        BTNS_N[0] = 1'b1;
        steps(60);

        // long hold and release
        t0 = cyc; BTNS_N[0] = 1'b0;
        wait_pulse(0, 0, 40, a);
        chk("hold_press", a - t0, 23);
        wait_pulse(0, 2, 150, b);
        chk("long_lat", b - t0, 123);
        while (cyc - t0 < 200) step();
        t0 = cyc; BTNS_N[0] = 1'b1;
        wait_pulse(0, 1, 40, a);
        chk("rel_lat", a - t0, 23);
        chk("rel_lvl", PRESSED[0], 0);
        steps(60);

        // both together, then release only 1
        BTNS_N = 2'b00;
        steps(23);
        chk("both_press", PRESS_P, 2'b11);
        BTNS_N[1] = 1'b1;
        steps(23);
        chk("rel_one", RELEASE_P, 2'b10);
        chk("rel_one_lvl", PRESSED, 2'b01);
        steps(150);

        // reset while button 0 is in the long-held state
        RST = 1'b1;
        #1;
        chk("rst_mid", {PRESSED, PRESS_P, RELEASE_P, LONG_P, TICK_1MS}, 0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold", {PRESSED, PRESS_P, RELEASE_P, LONG_P, TICK_1MS}, 0);
        model_reset();
        RST = 1'b0;
        t0 = cyc;
        wait_pulse(0, 0, 40, a);
        chk("rst_repress", a - t0, 23);
        wait_pulse(0, 2, 150, b);
        chk("rst_long", b - t0, 123);
        BTNS_N[0] = 1'b1;
        steps(60);

        // random bouncing on both channels
        for (int c = 0; c < NB; c++) rem[c] = 0;
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    BTNS_N[c] = ~BTNS_N[c];
                    rem[c] = ($urandom_range(0, 5) == 0) ?
                             $urandom_range(90, 160) : $urandom_range(1, 30);
                end
                rem[c]--;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout @cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
